// File: rtl/sd_pkg.sv
// Shared types and constants for the SD DAT-line transmit path.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STRT,
    ST_DATA,
    ST_CRC,
    ST_ENDB,
    ST_DONE
  } sd_tx_state_t;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic        SD_START_BIT = 1'b0;
  localparam logic        SD_END_BIT   = 1'b1;

endpackage

// File: rtl/sd_crc16_lane.sv
// Per-lane CRC16 (x^16+x^12+x^5+1), zero seed, MSB-first, one bit per enabled cycle.
module sd_crc16_lane
  import sd_pkg::*;
(
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        data_bit,
  output logic [15:0] crc
);

  logic fb;
  assign fb = crc[15] ^ data_bit;

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst)
      crc <= '0;
    else if (clr)
      crc <= '0;
    else if (en)
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

endmodule

// File: rtl/sd_data_tx_sequencer.sv
// Serializes one SD data block (start bit, payload, per-lane CRC16, end bit) onto DAT[3:0].
//
//   state | meaning
//   IDLE  | bus released, waiting for start with nonzero length
//   STRT  | start bit on active lanes, byte 0 requested
//   DATA  | payload bits shifting out MSB first
//   CRC   | 16 frozen CRC bits per active lane, MSB first
//   ENDB  | end bit on active lanes
//   DONE  | bus released, done pulse
module sd_data_tx_sequencer
  import sd_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic             sd_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bus_4bit,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [3:0]       dat_o,
  output logic             dat_oe,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  sd_tx_state_t     state;
  logic             mode4;
  logic [LEN_W-1:0] byte_cnt;
  logic [2:0]       bit_cnt;
  logic [3:0]       crc_cnt;
  logic [7:0]       sreg;

  logic        take;
  logic        shift;
  logic        need_byte;
  logic        crc_en;
  logic        crc_clr;
  logic [7:0]  src;
  logic [7:0]  sreg_nxt;
  logic [3:0]  nxt_bits;
  logic [3:0]  crc_idx;
  logic [3:0]  crc_bits;
  logic [3:0]  crc_lanes;
  logic [15:0] crc_q [4];

  // The CRCs advance on the same edge that puts a payload bit on the bus,
  // so entering CRC state they already include the last data bit.
  always_comb begin
    shift     = 1'b0;
    need_byte = 1'b0;
    case (state)
      ST_STRT: need_byte = 1'b1;
      ST_DATA: begin
        shift     = (bit_cnt != 3'd0);
        need_byte = (bit_cnt == 3'd0) && (byte_cnt != '0);
      end
      default: ;
    endcase
    take     = need_byte && data_valid;
    src      = take ? data_in : sreg;
    nxt_bits = mode4 ? src[7:4] : {3'b111, src[7]};
    sreg_nxt = mode4 ? {src[3:0], 4'h0} : {src[6:0], 1'b0};
    crc_en   = take || shift;
    crc_clr  = (state == ST_IDLE) && start && (blk_len != '0);
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sd_crc16_lane u_crc (
      .sd_clk   (sd_clk),
      .rst      (rst),
      .clr      (crc_clr),
      .en       (crc_en && (mode4 || (i == 0))),
      .data_bit (nxt_bits[i]),
      .crc      (crc_q[i])
    );
  end

  always_comb begin
    crc_idx = (state == ST_CRC) ? crc_cnt - 4'd1 : 4'd15;
    for (int i = 0; i < 4; i++)
      crc_bits[i] = crc_q[i][crc_idx];
    crc_lanes = mode4 ? crc_bits : {3'b111, crc_bits[0]};
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode4      <= 1'b0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      crc_cnt    <= '0;
      sreg       <= '0;
      dat_o      <= 4'hF;
      dat_oe     <= 1'b0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && (blk_len != '0)) begin
            state      <= ST_STRT;
            mode4      <= bus_4bit;
            byte_cnt   <= blk_len;
            dat_oe     <= 1'b1;
            busy       <= 1'b1;
            data_ready <= 1'b1;
            dat_o      <= bus_4bit ? {4{SD_START_BIT}} : {3'b111, SD_START_BIT};
          end
        end
        ST_STRT, ST_DATA: begin
          if (shift) begin
            dat_o   <= nxt_bits;
            sreg    <= sreg_nxt;
            bit_cnt <= bit_cnt - 3'd1;
            if ((bit_cnt == 3'd1) && (byte_cnt != '0))
              data_ready <= 1'b1;
          end else if (need_byte) begin
            if (data_valid) begin
              state    <= ST_DATA;
              dat_o    <= nxt_bits;
              sreg     <= sreg_nxt;
              bit_cnt  <= mode4 ? 3'd1 : 3'd7;
              byte_cnt <= byte_cnt - 1'b1;
            end else begin
              state    <= ST_IDLE;
              underrun <= 1'b1;
              dat_oe   <= 1'b0;
              busy     <= 1'b0;
              dat_o    <= 4'hF;
            end
          end else begin
            state   <= ST_CRC;
            crc_cnt <= 4'd15;
            dat_o   <= crc_lanes;
          end
        end
        ST_CRC: begin
          if (crc_cnt == 4'd0) begin
            state <= ST_ENDB;
            dat_o <= mode4 ? {4{SD_END_BIT}} : {3'b111, SD_END_BIT};
          end else begin
            crc_cnt <= crc_cnt - 4'd1;
            dat_o   <= crc_lanes;
          end
        end
        ST_ENDB: begin
          state  <= ST_DONE;
          done   <= 1'b1;
          dat_oe <= 1'b0;
          busy   <= 1'b0;
          dat_o  <= 4'hF;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_data_tx_sequencer.sv
// Directed bench for sd_data_tx_sequencer: table-driven block transfers plus
// hand sequences for zero-length/busy starts, underrun and mid-transfer reset.
module tb_sd_data_tx_sequencer;

  localparam int LEN_W = 12;

  logic             sd_clk = 1'b0;
  logic             rst;
  logic             start;
  logic             bus_4bit;
  logic [LEN_W-1:0] blk_len;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic [3:0]       dat_o;
  logic             dat_oe;
  logic             busy;
  logic             done;
  logic             underrun;

  sd_data_tx_sequencer #(.LEN_W(LEN_W)) dut (
    .sd_clk     (sd_clk),
    .rst        (rst),
    .start      (start),
    .bus_4bit   (bus_4bit),
    .blk_len    (blk_len),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dat_o      (dat_o),
    .dat_oe     (dat_oe),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 sd_clk = ~sd_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             m4;
    logic [LEN_W-1:0] len;
    logic [7:0]       pat;
    int               poke;   // cycle at which a stray start is driven (0 = none)
    logic [3:0][15:0] crc;    // expected CRC per lane; inactive lanes read as FFFF
    int               occ;    // expected dat_oe cycles
  } vec_t;

  vec_t vecs[5];

  // Sends one block of constant bytes and checks framing, payload, CRCs and timing.
  task automatic run_xfer(input vec_t v, input string tag);
    logic [3:0]  q[$];
    logic [3:0]  e;
    logic [3:0]  exp_nib;
    logic [15:0] lane_crc [4];
    int ready_n = 0, done_k = -1, busy_bad = 0, data_bad = 0, un_n = 0, idle_bad = 0;
    int n;
    @(negedge sd_clk);
    start = 1'b1; bus_4bit = v.m4; blk_len = v.len; data_in = v.pat; data_valid = 1'b1;
    for (int k = 1; k <= 6000 && done_k < 0; k++) begin
      @(negedge sd_clk);
      start    = (k == v.poke);
      bus_4bit = (k == v.poke) ? ~v.m4 : v.m4;
      blk_len  = (k == v.poke) ? LEN_W'(3) : v.len;
      if (dat_oe) begin
        q.push_back(dat_o);
        if (!busy) busy_bad++;
      end
      if (data_ready) ready_n++;
      if (underrun) un_n++;
      if (done) begin
        done_k = k;
        if (busy || dat_oe || dat_o != 4'hF) idle_bad++;
      end
    end
    start = 1'b0;
    n = q.size();
    for (int l = 0; l < 4; l++) lane_crc[l] = 16'hxxxx;
    if (n >= 18) begin
      for (int j = 0; j < n - 18; j++) begin
        exp_nib = v.m4 ? ((j % 2 == 0) ? v.pat[7:4] : v.pat[3:0])
                       : {3'b111, v.pat[7 - (j % 8)]};
        if (q[j + 1] !== exp_nib) data_bad++;
      end
      for (int b = 0; b < 16; b++) begin
        e = q[n - 17 + b];
        for (int l = 0; l < 4; l++) lane_crc[l][15 - b] = e[l];
      end
    end
    chk({tag, "_occupancy"}, n, v.occ);
    chk({tag, "_ready_count"}, ready_n, 32'(v.len));
    chk({tag, "_done_cycle"}, done_k, v.occ + 1);
    chk({tag, "_done_idle"}, idle_bad, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_payload"}, data_bad, 0);
    chk({tag, "_no_underrun"}, un_n, 0);
    chk({tag, "_start_bit"}, (n > 0) ? q[0] : 4'hx, v.m4 ? 4'h0 : 4'hE);
    chk({tag, "_end_bit"}, (n > 0) ? q[n - 1] : 4'hx, 4'hF);
    for (int l = 0; l < 4; l++)
      chk($sformatf("%s_crc_lane%0d", tag, l), lane_crc[l], v.crc[l]);
  endtask

  initial begin
    int bad, un_n, un_k, done_n, rdy, un_state;

    rst = 1'b1; start = 1'b0; bus_4bit = 1'b0; blk_len = '0; data_in = '0; data_valid = 1'b0;
    repeat (3) @(negedge sd_clk);
    chk("reset_dat_o", dat_o, 4'hF);
    chk("reset_flags", {dat_oe, busy, data_ready, done, underrun}, 5'b0);
    rst = 1'b0;

    // Zero-length start must be ignored
    @(negedge sd_clk);
    start = 1'b1; blk_len = '0; bus_4bit = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if ({dat_oe, busy, data_ready, done, underrun} != 5'b0 || dat_o != 4'hF) bad++;
      @(negedge sd_clk);
    end
    chk("zero_len_ignored", bad, 0);

    vecs[0] = '{1'b0, 12'd1,    8'h80, 5,   {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h9188}, 26};
    vecs[1] = '{1'b0, 12'd512,  8'hFF, 0,   {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FA1}, 4114};
    vecs[2] = '{1'b1, 12'd2048, 8'hFF, 100, {16'h7FA1, 16'h7FA1, 16'h7FA1, 16'h7FA1}, 4114};
    vecs[3] = '{1'b1, 12'd1,    8'h80, 0,   {16'h2042, 16'h0000, 16'h0000, 16'h0000}, 20};
    vecs[4] = '{1'b0, 12'd1,    8'h00, 0,   {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000}, 26};
    for (int i = 0; i < 5; i++)
      run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Underrun: 4-bit, 4 bytes, byte 2 missing
    @(negedge sd_clk);
    start = 1'b1; bus_4bit = 1'b1; blk_len = 12'd4; data_in = 8'h3C; data_valid = 1'b1;
    un_n = 0; un_k = -1; done_n = 0; rdy = 0; un_state = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge sd_clk);
      start = 1'b0;
      data_valid = 1'b1;
      if (data_ready) begin
        rdy++;
        if (rdy == 3) data_valid = 1'b0;
      end
      if (underrun) begin
        un_n++;
        if (un_k < 0) begin
          un_k = k;
          un_state = {dat_oe, busy, dat_o};
        end
      end
      if (done) done_n++;
    end
    chk("underrun_count", un_n, 1);
    chk("underrun_cycle", un_k, 6);
    chk("underrun_bus_released", un_state, {1'b0, 1'b0, 4'hF});
    chk("underrun_no_done", done_n, 0);
    run_xfer('{1'b1, 12'd1, 8'h00, 0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 20}, "after_underrun");

    // Asynchronous reset in the middle of DATA
    @(negedge sd_clk);
    start = 1'b1; bus_4bit = 1'b0; blk_len = 12'd512; data_in = 8'hFF; data_valid = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    repeat (20) @(negedge sd_clk);
    chk("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_dat_o", dat_o, 4'hF);
    chk("async_reset_flags", {dat_oe, busy, data_ready, done, underrun}, 5'b0);
    @(negedge sd_clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge sd_clk);
      if (done || underrun || busy || dat_oe) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    run_xfer('{1'b0, 12'd1, 8'h00, 0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000}, 26}, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
